// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period meter and its display consumers.
package period_meter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } pm_state_t;

  localparam int          CNT_W_DEF   = 32;
  localparam int unsigned TIMEOUT_DEF = 32'd200_000_000;
  localparam int unsigned CLK_HZ      = 32'd100_000_000;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus an edge register; reports single-cycle rise/fall
// of an asynchronous level. Reusable for button and sensor lines.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1_r;
  logic s2_r;
  logic s3_r;

  // synchroniser chain (s1, s2) followed by the edge-compare register s3
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= din;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign rise = s2_r & ~s3_r;
  assign fall = ~s2_r & s3_r;

endmodule

// File: rtl/period_meter.sv
// Period meter: counts clk cycles between rising edges of sig_in, with a sticky
// stall timeout. Define PERIOD_METER_DUTY_EN to also report the high time.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int          CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             timeout
`ifdef PERIOD_METER_DUTY_EN
  ,
  output logic [CNT_W-1:0] high_cycles
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 32'd1);

  pm_state_t        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             rise_s;
  logic             fall_s;

  sync_edge_detect u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (sig_in),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  assign cnt_inc_s = cnt_r + CNT_ONE;

  // measurement FSM; a rise in the terminal-count cycle takes priority over timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      period       <= {CNT_W{1'b0}};
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r <= {CNT_W{1'b0}};
          if (rise_s) begin
            state_r <= ST_MEASURE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MEASURE: begin
          if (rise_s) begin
            period       <= cnt_inc_s;
            period_valid <= 1'b1;
            timeout      <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
            state_r      <= ST_MEASURE;
          end else if (cnt_r == TMO_LAST) begin
            timeout <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_IDLE;
          end else begin
            cnt_r   <= cnt_inc_s;
            state_r <= ST_MEASURE;
          end
        end
        default: begin
          cnt_r   <= {CNT_W{1'b0}};
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] hi_cnt_r;
  logic             fall_seen_r;

  // high time: latched on fall, published with period; no fall means fully high
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_cnt_r    <= {CNT_W{1'b0}};
      fall_seen_r <= 1'b0;
      high_cycles <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rise_s) begin
            hi_cnt_r    <= {CNT_W{1'b0}};
            fall_seen_r <= 1'b0;
          end else begin
            hi_cnt_r    <= hi_cnt_r;
            fall_seen_r <= fall_seen_r;
          end
        end
        ST_MEASURE: begin
          if (rise_s) begin
            high_cycles <= fall_seen_r ? hi_cnt_r : cnt_inc_s;
            hi_cnt_r    <= {CNT_W{1'b0}};
            fall_seen_r <= 1'b0;
          end else if (fall_s) begin
            hi_cnt_r    <= cnt_inc_s;
            fall_seen_r <= 1'b1;
          end else begin
            hi_cnt_r    <= hi_cnt_r;
            fall_seen_r <= fall_seen_r;
          end
        end
        default: begin
          hi_cnt_r    <= {CNT_W{1'b0}};
          fall_seen_r <= 1'b0;
        end
      endcase
    end
  end
`else
  logic unused_fall_s;
  assign unused_fall_s = fall_s;
`endif

endmodule
